// File: rtl/hs2bram_cast_pkg.sv
// -----------------------------------------------------------------------------
// hs2bram_cast_pkg
//  Types and helpers for the handshake <-> BRAM cast blocks.
//  - cast_state_t   : FSM states, also used by the BRAM-to-handshake cast
//  - cast_cnt_width : bit width of a counter indexing n elements (minimum 1)
// -----------------------------------------------------------------------------
package hs2bram_cast_pkg;

  typedef enum logic [1:0] {
    CAST_ACCEPT = 2'd0,
    CAST_WRITE  = 2'd1,
    CAST_FULL   = 2'd2
  } cast_state_t;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cast_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs2bram_cast_ram_block.sv
// -----------------------------------------------------------------------------
// ram_block
//  Simple dual-port RAM with registered read, inferred as block RAM.
//  Ports:
//   clk                      clock
//   addr0/ce0/we0/d0/q0      port 0: read/write, q0 valid one cycle after ce0
//   addr1/ce1/we1/d1         port 1: write-only
//  Contents are never reset. An address >= MEM_SIZE reads undefined data
//  and an out-of-range write is dropped.
// -----------------------------------------------------------------------------
module ram_block #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 100
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] addr0,
  input  logic              ce0,
  input  logic              we0,
  input  logic [DWIDTH-1:0] d0,
  output logic [DWIDTH-1:0] q0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic              ce1,
  input  logic              we1,
  input  logic [DWIDTH-1:0] d1
);

  logic [DWIDTH-1:0] mem [0:MEM_SIZE-1];
  logic [DWIDTH-1:0] q0_q;

  // Memory and read register stay in one reset-free process so the tools
  // can map them straight onto a block RAM primitive.
  always_ff @(posedge clk) begin
    if (ce0) begin
      if (we0) begin
        mem[addr0] <= d0;
      end else begin
        q0_q <= mem[addr0];
      end
    end
    if (ce1 && we1) begin
      mem[addr1] <= d1;
    end
  end

  assign q0 = q0_q;

endmodule

// File: rtl/hs2bram_cast.sv
// -----------------------------------------------------------------------------
// hs2bram_cast
//  Handshake-to-BRAM cast. Accepts IN_SIZE-element vectors over valid/ready,
//  writes them one element per cycle into a ram_block, and once ADDR_RANGE
//  elements are stored hands the buffer to a downstream consumer.
//  Ports:
//   clk, rst        clock; asynchronous active-high reset
//   data_in         IN_SIZE x IN_WIDTH input vector
//   data_in_valid   producer valid
//   data_in_ready   high while waiting for a vector
//   address0, ce0   consumer read address / enable
//   q0              read data, one cycle after ce0
//   out_start       high while a complete frame is held for the consumer
//   out_done        consumer releases the frame (one-cycle pulse)
// -----------------------------------------------------------------------------
module hs2bram_cast
  import hs2bram_cast_pkg::*;
#(
  parameter int IN_SIZE    = 8,
  parameter int IN_WIDTH   = 8,
  parameter int ADDR_RANGE = 100,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   data_in [IN_SIZE-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic                  ce0,
  output logic [IN_WIDTH-1:0]   q0,
  output logic                  out_start,
  input  logic                  out_done
);

  localparam int CNT_WIDTH = cast_cnt_width(IN_SIZE);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  cast_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [CNT_WIDTH-1:0]  data_cnt_q, data_cnt_d;
  logic [IN_WIDTH-1:0]   data_buff_q [IN_SIZE-1:0];
  logic [IN_WIDTH-1:0]   data_buff_d [IN_SIZE-1:0];

  logic                  capture;
  logic                  addr_last;
  logic                  data_last;
  logic                  ram_we;
  logic [IN_WIDTH-1:0]   ram_wdata;

  // Decoded from state alone so an asynchronous reset moves them at once.
  assign data_in_ready = (state_q == CAST_ACCEPT);
  assign out_start     = (state_q == CAST_FULL);
  assign capture       = data_in_valid && data_in_ready;

  // Compare at 32-bit width so no parameter value is silently truncated.
  assign addr_last = (32'(addr_cnt_q) == ADDR_RANGE - 1);
  assign data_last = (32'(data_cnt_q) == IN_SIZE - 1);

  assign ram_wdata = data_buff_q[data_cnt_q];

  always_comb begin
    data_buff_d = data_buff_q;
    if (capture) begin
      data_buff_d = data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    data_cnt_d = data_cnt_q;
    ram_we     = 1'b0;
    case (state_q)
      CAST_ACCEPT: begin
        if (data_in_valid) begin
          state_d    = CAST_WRITE;
          data_cnt_d = '0;
        end
      end
      CAST_WRITE: begin
        ram_we     = 1'b1;
        addr_cnt_d = addr_cnt_q + ADDR_ONE;
        data_cnt_d = data_cnt_q + CNT_ONE;
        // Frame end wins: a vector overhanging the frame is truncated and
        // its remaining elements are dropped.
        if (addr_last) begin
          state_d = CAST_FULL;
        end else if (data_last) begin
          state_d = CAST_ACCEPT;
        end
      end
      CAST_FULL: begin
        if (out_done) begin
          state_d    = CAST_ACCEPT;
          addr_cnt_d = '0;
          data_cnt_d = '0;
        end
      end
      default: begin
        state_d = CAST_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CAST_ACCEPT;
      addr_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  // Pure datapath; only read while in WRITE, which always follows a capture.
  always_ff @(posedge clk) begin
    data_buff_q <= data_buff_d;
  end

  ram_block #(
    .DWIDTH   (IN_WIDTH),
    .AWIDTH   (ADDR_WIDTH),
    .MEM_SIZE (ADDR_RANGE)
  ) u_ram (
    .clk   (clk),
    .addr0 (address0),
    .ce0   (ce0),
    .we0   (1'b0),
    .d0    ({IN_WIDTH{1'b0}}),
    .q0    (q0),
    .addr1 (addr_cnt_q),
    .ce1   (ram_we),
    .we1   (ram_we),
    .d1    (ram_wdata)
  );

endmodule

// File: tb/tb_hs2bram_cast.sv
// -----------------------------------------------------------------------------
// tb_hs2bram_cast
//  Three instances: A (IN_SIZE=8, ADDR_RANGE=16), B (IN_SIZE=8, ADDR_RANGE=20),
//  C (IN_SIZE=1, ADDR_RANGE=3). Inputs are driven and outputs sampled on the
//  falling edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_hs2bram_cast;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A
  logic [7:0] a_data [7:0];
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [3:0] a_addr = '0;
  logic       a_ce = 1'b0;
  logic [7:0] a_q;
  logic       a_start;
  logic       a_done = 1'b0;

  // Instance B
  logic [7:0] b_data [7:0];
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [4:0] b_addr = '0;
  logic       b_ce = 1'b0;
  logic [7:0] b_q;
  logic       b_start;
  logic       b_done = 1'b0;

  // Instance C
  logic [7:0] c_data [0:0];
  logic       c_valid = 1'b0;
  logic       c_ready;
  logic [1:0] c_addr = '0;
  logic       c_ce = 1'b0;
  logic [7:0] c_q;
  logic       c_start;
  logic       c_done = 1'b0;

  hs2bram_cast #(.IN_SIZE(8), .IN_WIDTH(8), .ADDR_RANGE(16), .ADDR_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data), .data_in_valid(a_valid),
    .data_in_ready(a_ready), .address0(a_addr), .ce0(a_ce), .q0(a_q),
    .out_start(a_start), .out_done(a_done)
  );

  hs2bram_cast #(.IN_SIZE(8), .IN_WIDTH(8), .ADDR_RANGE(20), .ADDR_WIDTH(5)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data), .data_in_valid(b_valid),
    .data_in_ready(b_ready), .address0(b_addr), .ce0(b_ce), .q0(b_q),
    .out_start(b_start), .out_done(b_done)
  );

  hs2bram_cast #(.IN_SIZE(1), .IN_WIDTH(8), .ADDR_RANGE(3), .ADDR_WIDTH(2)) dut_c (
    .clk(clk), .rst(rst), .data_in(c_data), .data_in_valid(c_valid),
    .data_in_ready(c_ready), .address0(c_addr), .ce0(c_ce), .q0(c_q),
    .out_start(c_start), .out_done(c_done)
  );

  // ---- stimulus helpers (called on a falling edge) --------------------------
  task automatic a_push(input int base, input int waits);
    for (int i = 0; i < 8; i++) a_data[i] = 8'(base + i);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (waits) @(negedge clk);
    $display("a push base %0d", base);
  endtask

  task automatic b_push(input int base, input int waits);
    for (int i = 0; i < 8; i++) b_data[i] = 8'(base + i);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    repeat (waits) @(negedge clk);
    $display("b push base %0d", base);
  endtask

  task automatic a_read(input int addr, output logic [7:0] val);
    a_addr = 4'(addr);
    a_ce   = 1'b1;
    @(negedge clk);
    val  = a_q;
    a_ce = 1'b0;
    $display("a read [%0d] = %0d", addr, val);
  endtask

  task automatic b_read(input int addr, output logic [7:0] val);
    b_addr = 5'(addr);
    b_ce   = 1'b1;
    @(negedge clk);
    val  = b_q;
    b_ce = 1'b0;
    $display("b read [%0d] = %0d", addr, val);
  endtask

  task automatic c_read(input int addr, output logic [7:0] val);
    c_addr = 2'(addr);
    c_ce   = 1'b1;
    @(negedge clk);
    val  = c_q;
    c_ce = 1'b0;
    $display("c read [%0d] = %0d", addr, val);
  endtask

  // ---- scenarios -------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", a_ready); else pass_cnt++;
    total_cnt++; if (a_start !== 1'b0) $display("FAIL reset_a_start: got %b want 0", a_start); else pass_cnt++;
    total_cnt++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", b_ready); else pass_cnt++;
    total_cnt++; if (c_start !== 1'b0) $display("FAIL reset_c_start: got %b want 0", c_start); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL idle_a_ready: got %b want 1", a_ready); else pass_cnt++;
  endtask

  task automatic test_frame_fill();
    logic [7:0] v;
    a_push(0, 8);
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t1_start_half: got %b want 0", a_start); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t1_ready_half: got %b want 1", a_ready); else pass_cnt++;
    a_push(8, 7);
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t1_start_early: got %b want 0", a_start); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_start !== 1'b1) $display("FAIL t1_start_full: got %b want 1", a_start); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL t1_ready_full: got %b want 0", a_ready); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      a_read(i, v);
      total_cnt++; if (v !== 8'(i)) $display("FAIL t1_read[%0d]: got %0d want %0d", i, v, i); else pass_cnt++;
    end
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL t1_ready_reads: got %b want 0", a_ready); else pass_cnt++;
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t1_ready_release: got %b want 1", a_ready); else pass_cnt++;
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t1_start_release: got %b want 0", a_start); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) a_data[i] = 8'(40 + i);
    a_valid = 1'b1;
    // Valid stays high and data keeps changing while the vector is written.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) a_data[i] = 8'(200 + k + i);
      if (k == 8) begin
        total_cnt++; if (a_ready !== 1'b0) $display("FAIL t3_ready_busy: got %b want 0", a_ready); else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t3_ready_back: got %b want 1", a_ready); else pass_cnt++;
    a_valid = 1'b0;
    a_push(50, 8);
    total_cnt++; if (a_start !== 1'b1) $display("FAIL t3_start_full: got %b want 1", a_start); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      a_read(i, v);
      total_cnt++; if (v !== 8'(40 + i)) $display("FAIL t3_read[%0d]: got %0d want %0d", i, v, 40 + i); else pass_cnt++;
    end
    a_read(8, v);
    total_cnt++; if (v !== 8'd50) $display("FAIL t3_read[8]: got %0d want 50", v); else pass_cnt++;
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t3_ready_release: got %b want 1", a_ready); else pass_cnt++;
  endtask

  task automatic test_out_done();
    logic [7:0] v;
    a_push(100, 8);
    a_done = 1'b1;                     // pulse while in ACCEPT
    @(negedge clk);
    a_done = 1'b0;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t4_ready_accept_done: got %b want 1", a_ready); else pass_cnt++;
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t4_start_accept_done: got %b want 0", a_start); else pass_cnt++;
    for (int i = 0; i < 8; i++) a_data[i] = 8'(108 + i);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    a_done  = 1'b1;                    // pulse while in WRITE
    @(negedge clk);
    a_done  = 1'b0;
    repeat (7) @(negedge clk);
    total_cnt++; if (a_start !== 1'b1) $display("FAIL t4_start_full: got %b want 1", a_start); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      a_read(i, v);
      total_cnt++; if (v !== 8'(100 + i)) $display("FAIL t4_read[%0d]: got %0d want %0d", i, v, 100 + i); else pass_cnt++;
    end
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t4_ready_release: got %b want 1", a_ready); else pass_cnt++;
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t4_start_release: got %b want 0", a_start); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) a_data[i] = 8'(90 + i);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL t5_ready_writing: got %b want 0", a_ready); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t5_ready_async: got %b want 1", a_ready); else pass_cnt++;
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t5_start_async: got %b want 0", a_start); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    a_push(60, 8);
    a_push(68, 8);
    total_cnt++; if (a_start !== 1'b1) $display("FAIL t5_start_full: got %b want 1", a_start); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (a_start !== 1'b0) $display("FAIL t5_start_fall: got %b want 0", a_start); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL t5_ready_rise: got %b want 1", a_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    a_read(0, v);
    total_cnt++; if (v !== 8'd60) $display("FAIL t5_read[0]: got %0d want 60", v); else pass_cnt++;
    a_read(7, v);
    total_cnt++; if (v !== 8'd67) $display("FAIL t5_read[7]: got %0d want 67", v); else pass_cnt++;
    a_read(15, v);
    total_cnt++; if (v !== 8'd75) $display("FAIL t5_read[15]: got %0d want 75", v); else pass_cnt++;
  endtask

  task automatic test_partial_vector();
    logic [7:0] v;
    b_push(0, 8);
    b_push(8, 8);
    total_cnt++; if (b_ready !== 1'b1) $display("FAIL t2_ready_two: got %b want 1", b_ready); else pass_cnt++;
    b_push(16, 3);
    total_cnt++; if (b_start !== 1'b0) $display("FAIL t2_start_early: got %b want 0", b_start); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (b_start !== 1'b1) $display("FAIL t2_start_full: got %b want 1", b_start); else pass_cnt++;
    total_cnt++; if (b_ready !== 1'b0) $display("FAIL t2_ready_full: got %b want 0", b_ready); else pass_cnt++;
    // A vector offered while FULL must wait, then be taken intact.
    for (int i = 0; i < 8; i++) b_data[i] = 8'(70 + i);
    b_valid = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (b_ready !== 1'b0) $display("FAIL t2_ready_stall: got %b want 0", b_ready); else pass_cnt++;
    for (int i = 16; i < 20; i++) begin
      b_read(i, v);
      total_cnt++; if (v !== 8'(i)) $display("FAIL t2_read[%0d]: got %0d want %0d", i, v, i); else pass_cnt++;
    end
    b_read(0, v);
    total_cnt++; if (v !== 8'd0) $display("FAIL t2_read[0]: got %0d want 0", v); else pass_cnt++;
    b_read(3, v);
    total_cnt++; if (v !== 8'd3) $display("FAIL t2_read[3]: got %0d want 3", v); else pass_cnt++;
    b_done = 1'b1;
    @(negedge clk);
    b_done = 1'b0;
    total_cnt++; if (b_ready !== 1'b1) $display("FAIL t2_ready_release: got %b want 1", b_ready); else pass_cnt++;
    @(negedge clk);
    b_valid = 1'b0;
    repeat (8) @(negedge clk);
    b_read(0, v);
    total_cnt++; if (v !== 8'd70) $display("FAIL t2_stalled[0]: got %0d want 70", v); else pass_cnt++;
    b_read(7, v);
    total_cnt++; if (v !== 8'd77) $display("FAIL t2_stalled[7]: got %0d want 77", v); else pass_cnt++;
  endtask

  task automatic test_in_size_one();
    logic [7:0] v;
    for (int n = 5; n <= 7; n++) begin
      c_data[0] = 8'(n);
      c_valid   = 1'b1;
      @(negedge clk);
      c_valid = 1'b0;
      $display("c push %0d", n);
      total_cnt++; if (c_ready !== 1'b0) $display("FAIL t6_ready_busy[%0d]: got %b want 0", n, c_ready); else pass_cnt++;
      @(negedge clk);
      if (n < 7) begin
        total_cnt++; if (c_ready !== 1'b1) $display("FAIL t6_ready_back[%0d]: got %b want 1", n, c_ready); else pass_cnt++;
      end else begin
        total_cnt++; if (c_start !== 1'b1) $display("FAIL t6_start_full: got %b want 1", c_start); else pass_cnt++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      c_read(i, v);
      total_cnt++; if (v !== 8'(5 + i)) $display("FAIL t6_read[%0d]: got %0d want %0d", i, v, 5 + i); else pass_cnt++;
    end
    c_done = 1'b1;
    @(negedge clk);
    c_done = 1'b0;
    total_cnt++; if (c_ready !== 1'b1) $display("FAIL t6_ready_release: got %b want 1", c_ready); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      a_data[i] = '0;
      b_data[i] = '0;
    end
    c_data[0] = '0;
    test_reset();
    test_frame_fill();
    test_backpressure();
    test_out_done();
    test_async_reset();
    test_partial_vector();
    test_in_size_one();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
